act_pipe: RTL and testbench

ACT_PIPE -- requirements
Module: act_pipe

---
 rtl/act_pkg.sv | 24 ++
 rtl/act_lane.sv | 59 +++++
 rtl/act_pipe.sv | 132 +++++++++++++
 tb/tb_act_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared definitions for the activation pipe: mode encodings
// and saturation-limit helpers.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_RELU  = 2'd0,
    ACT_LEAKY = 2'd1,
    ACT_CLIP  = 2'd2,
    ACT_SAT   = 2'd3
  } act_mode_e;

  function automatic logic signed [63:0] sat_smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [63:0] sat_umax(input int w);
    return (64'sd1 <<< w) - 64'sd1;
  endfunction

endpackage

// File: rtl/act_lane.sv
// Combinational per-lane activation: rectify, leak, clip and
// saturate a 2W-bit signed accumulator down to W bits.
module act_lane
  import act_pkg::*;
#(
  parameter int DW = 16,
  parameter int LS = 3
) (
  input  logic signed [2*DW-1:0] i_x,
  input  act_mode_e              i_mode,
  input  logic        [DW-1:0]   i_cap,
  output logic        [DW-1:0]   o_y,
  output logic                   o_sat
);

  localparam logic signed [2*DW-1:0] L_SMAX = (2*DW)'(sat_smax(DW));
  localparam logic signed [2*DW-1:0] L_SMIN = (2*DW)'(sat_smin(DW));
  localparam logic signed [2*DW-1:0] L_UMAX = (2*DW)'(sat_umax(DW));

  logic                   w_neg;
  logic                   w_uovf;
  logic        [DW-1:0]   w_relu;
  logic signed [2*DW-1:0] w_lin;
  logic                   w_shi;
  logic                   w_slo;
  logic        [DW-1:0]   w_ssat;

  assign w_neg  = i_x[2*DW-1];
  assign w_uovf = !w_neg && (i_x > L_UMAX);
  assign w_relu = w_neg  ? '0 :
                  w_uovf ? '1 : i_x[DW-1:0];

  // Leak only applies in leaky mode; saturate-only passes raw input.
  assign w_lin  = (i_mode == ACT_LEAKY && w_neg) ? (i_x >>> LS) : i_x;
  assign w_shi  = w_lin > L_SMAX;
  assign w_slo  = w_lin < L_SMIN;
  assign w_ssat = w_shi ? L_SMAX[DW-1:0] :
                  w_slo ? L_SMIN[DW-1:0] : w_lin[DW-1:0];

  always_comb begin
    o_y   = '0;
    o_sat = 1'b0;
    unique case (i_mode)
      ACT_RELU: begin
        o_y   = w_relu;
        o_sat = w_uovf;
      end
      ACT_CLIP: begin
        o_y   = (w_relu > i_cap) ? i_cap : w_relu;
        o_sat = w_uovf;
      end
      ACT_LEAKY, ACT_SAT: begin
        o_y   = w_ssat;
        o_sat = w_shi | w_slo;
      end
    endcase
  end

endmodule

// File: rtl/act_pipe.sv
// Two-stage valid/ready activation pipe over NUM_CH lanes.
// Define ACT_PIPE_SAT_CNT_EN to add the saturation counter.
module act_pipe
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [1:0]                     cfg_mode,
  input  logic [DATA_WIDTH-1:0]          cfg_cap,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH*2*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_data
`ifdef ACT_PIPE_SAT_CNT_EN
  ,
  input  logic                           sat_clr,
  output logic [15:0]                    sat_cnt
`endif
);

  localparam int DW   = DATA_WIDTH;
  localparam int L_CW = $clog2(NUM_CH + 1);

  act_mode_e                r_mode;
  logic [DW-1:0]            r_cap;
  logic                     r_s1_vld;
  logic [NUM_CH*2*DW-1:0]   r_s1_data;
  act_mode_e                r_s1_mode;
  logic [DW-1:0]            r_s1_cap;
  logic                     r_s2_vld;
  logic [NUM_CH*DW-1:0]     r_s2_data;

  logic                     w_s2_adv;
  logic                     w_s1_adv;
  logic                     w_acc;
  logic [NUM_CH*DW-1:0]     w_y;
  logic [NUM_CH-1:0]        w_sat;
  logic [L_CW-1:0]          w_nsat;

  assign w_s2_adv  = !r_s2_vld || out_ready;
  assign w_s1_adv  = !r_s1_vld || w_s2_adv;
  assign w_acc     = in_valid && w_s1_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_vld;
  assign out_data  = r_s2_data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    act_lane #(
      .DW (DW),
      .LS (LEAK_SHIFT)
    ) u_lane (
      .i_x    (r_s1_data[g*2*DW +: 2*DW]),
      .i_mode (r_s1_mode),
      .i_cap  (r_s1_cap),
      .o_y    (w_y[g*DW +: DW]),
      .o_sat  (w_sat[g])
    );
  end

  always_comb begin
    w_nsat = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_nsat = w_nsat + L_CW'(w_sat[i]);
  end

`ifdef ACT_PIPE_SAT_CNT_EN
  logic [L_CW-1:0] r_s2_nsat;
  logic [15:0]     r_sat_cnt;
  logic [16:0]     w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_sat_cnt} + 17'(r_s2_nsat);
  assign sat_cnt   = r_sat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_nsat <= '0;
      r_sat_cnt <= '0;
    end else begin
      if (w_s2_adv && r_s1_vld)
        r_s2_nsat <= w_nsat;
      if (sat_clr)
        r_sat_cnt <= '0;
      else if (r_s2_vld && out_ready)
        r_sat_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end
`else
  logic w_unused_nsat;
  assign w_unused_nsat = ^w_nsat;
`endif

  // Mode/cap are sampled before this edge's cfg write, so a beat
  // accepted together with cfg_we keeps the previous settings.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode    <= ACT_RELU;
      r_cap     <= '1;
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_mode <= ACT_RELU;
      r_s1_cap  <= '1;
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      if (cfg_we) begin
        r_mode <= act_mode_e'(cfg_mode);
        r_cap  <= cfg_cap;
      end
      if (w_s1_adv) begin
        r_s1_vld <= in_valid;
        if (w_acc) begin
          r_s1_data <= in_data;
          r_s1_mode <= r_mode;
          r_s1_cap  <= r_cap;
        end
      end
      if (w_s2_adv) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld)
          r_s2_data <= w_y;
      end
    end
  end

endmodule

// File: tb/tb_act_pipe.sv
// Scoreboard bench for act_pipe (DATA_WIDTH=16, NUM_CH=2,
// LEAK_SHIFT=3) with a plain-arithmetic reference model.
module tb_act_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_cap = 16'hFFFF;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
`ifdef ACT_PIPE_SAT_CNT_EN
  logic        sat_clr = 1'b0;
  logic [15:0] sat_cnt;
`endif

  act_pipe #(
    .DATA_WIDTH (16),
    .NUM_CH     (2),
    .LEAK_SHIFT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_mode  (cfg_mode),
    .cfg_cap   (cfg_cap),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ACT_PIPE_SAT_CNT_EN
    ,
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_emit = 0;
  int          m_mode = 0;
  logic [15:0] m_cap = 16'hFFFF;
  logic [31:0] exp_q[$];
  logic [31:0] got[$];

  function automatic longint clamp_s(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [15:0] ref_lane(input int m,
      input logic [31:0] xb, input logic [15:0] c);
    longint x, r, v;
    x = longint'($signed(xb));
    r = (x < 0) ? 0 : ((x > 65535) ? 65535 : x);
    case (m)
      0: v = r;
      1: v = clamp_s((x < 0) ? -((-x + 7) / 8) : x);
      2: v = (r < longint'(c)) ? r : longint'(c);
      default: v = clamp_s(x);
    endcase
    return v[15:0];
  endfunction

  function automatic logic [31:0] exp_beat(input logic [63:0] d,
      input int m, input logic [15:0] c);
    return {ref_lane(m, d[63:32], c), ref_lane(m, d[31:0], c)};
  endfunction

  function automatic logic [31:0] rnd_lane();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom_range(0, 70000);
      1: v = -$urandom_range(0, 300000);
      2: v = $urandom();
      default: v = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h0000_FFFF;
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
      input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  // One clock: accept/cfg decided at negedge, inputs retire after posedge.
  task automatic tick();
    bit acc;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      exp_q.push_back(exp_beat(in_data, m_mode, m_cap));
      n_acc++;
    end
    if (cfg_we) begin
      m_mode = int'(cfg_mode);
      m_cap  = cfg_cap;
    end
    @(posedge clk);
    #1;
    if (acc) in_valid = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic wait_acc();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (in_valid && k < 50);
    if (in_valid) begin
      chk("accept_timeout", 64'(in_valid), 64'd0);
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    wait_acc();
  endtask

  task automatic send_chk(input string nm, input logic [63:0] d,
      input logic [31:0] e);
    int k;
    send(d);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    if (out_valid) chk(nm, 64'(out_data), 64'(e));
    else chk({nm, "_timeout"}, 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] m, input logic [15:0] c);
    cfg_we   = 1'b1;
    cfg_mode = m;
    cfg_cap  = c;
    tick();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 100) begin
      tick();
      k++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got.push_back(out_data);
      n_emit++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat got=%h required=none", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_err++;
          $display("FAIL scoreboard got=%h required=%h", out_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, e0;
    logic [31:0] held;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
`ifdef ACT_PIPE_SAT_CNT_EN
    chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Mode 0 straight from reset, with latency check.
    in_valid = 1'b1;
    in_data  = {32'hFFFF_FFF0, 32'h0000_1234};
    tick();
    chk("first_accept", 64'(in_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2", 64'(out_valid), 64'd1);
    chk("relu_basic", 64'(out_data), 64'h0000_1234);
    @(posedge clk);
    #1;
    send_chk("relu_usat", {32'h0001_0000, 32'h0000_1234}, 32'hFFFF_1234);

    cfg_write(2'd1, 16'hFFFF);
    send_chk("leaky_neg_pos", {32'h0001_0000, 32'hFFFF_FFB0}, 32'h7FFF_FFF6);
    send_chk("leaky_min", {32'h8000_0000, 32'h0000_0000}, 32'h8000_0000);

    cfg_write(2'd2, 16'h0100);
    send_chk("clip_cap", {32'h0000_0200, 32'h0000_0080}, 32'h0100_0080);
    send_chk("clip_neg", {32'hFFFF_FFFF, 32'h0000_0000}, 32'h0000_0000);

    cfg_write(2'd3, 16'hFFFF);
    send_chk("sat_only", {32'h0000_7FFF, 32'hFFFF_7FFF}, 32'h7FFF_8000);
    drain();

    // Backpressure: three back-to-back beats, output stalled 5 cycles.
    cfg_write(2'd0, 16'hFFFF);
    out_ready = 1'b0;
    a0 = n_acc;
    e0 = n_emit;
    seen = 1'b0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      if (!in_valid) begin
        in_valid = 1'b1;
        in_data  = {32'd100 + 32'(c), 32'd200 + 32'(c)};
      end
      tick();
      if (out_valid) begin
        if (seen) chk("bp_hold", 64'(out_data), 64'(held));
        else held = out_data;
        seen = 1'b1;
      end
    end
    chk("bp_accepted", 64'(n_acc - a0), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_acc();
    drain();
    chk("bp_emitted", 64'(n_emit - e0), 64'd3);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send({32'h0000_0011, 32'h0000_0022});
    send({32'h0000_0033, 32'h0000_0044});
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
`ifdef ACT_PIPE_SAT_CNT_EN
    chk("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
`endif
    exp_q.delete();
    m_mode = 0;
    m_cap  = 16'hFFFF;
    e0 = n_emit;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("midrst_no_emit", 64'(n_emit - e0), 64'd0);

    // cfg write coinciding with beat B of A,B,C.
    send({32'hFFFF_FFB0, 32'h0000_1234});
    cfg_we   = 1'b1;
    cfg_mode = 2'd1;
    cfg_cap  = 16'hFFFF;
    send({32'hFFFF_FFB0, 32'h0000_1234});
    send({32'hFFFF_FFB0, 32'h0000_1234});
    drain();
    chk("cfg_beat_a", 64'(got[got.size()-3]), 64'h0000_1234);
    chk("cfg_beat_b", 64'(got[got.size()-2]), 64'h0000_1234);
    chk("cfg_beat_c", 64'(got[got.size()-1]), 64'hFFF6_1234);

    // Randomised traffic, ready and configuration.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        cfg_we   = 1'b1;
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_cap  = 16'($urandom());
      end
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = {rnd_lane(), rnd_lane()};
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
